// File: rtl/z80_read_cycle_ctrl.sv
// z80_read_cycle_ctrl: synchronizes Z80 read/int-ack strobes, drives one-hot data-in selects
// and stretches each cycle with WAIT_n for a per-target count.
module z80_read_cycle_ctrl #(
  parameter logic [3:0] ROM_PAGE     = 4'hF,
  parameter logic [7:0] LED_PORT     = 8'hFF,
  parameter logic [7:0] IOBYTE_PORT  = 8'hEF,
  parameter int unsigned ROM_WAIT     = 6,
  parameter int unsigned RAM_WAIT     = 4,
  parameter int unsigned IO_WAIT      = 12,
  parameter int unsigned HOLD_TIMEOUT = 1023
) (
  input  logic        pll0_250MHz,
  input  logic        n_reset,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_m1_n,
  input  logic [15:0] cpu_addr,
  input  logic        boot_rom_en,
  input  logic        cpu_reset_req,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        inPortcon_cs,
  output logic        inLED_cs,
  output logic        iobyteIn_cs,
  output logic        reset_cs,
  output logic        cpu_wait_n,
  output logic        timeout_err
);
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_HOLD, S_RELEASE} state_t;
  typedef enum logic [1:0] {K_MEM, K_IO, K_INT} kind_t;
  state_t state_q, state_d;
  kind_t kind_q, kind_d;
  logic [3:0] sync1_q, sync2_q;
  logic [5:0] cs_q, cs_d;
  logic [5:0] wait_cnt_q, wait_cnt_d, dec_wait;
  logic [9:0] hold_cnt_q, hold_cnt_d;
  logic [4:0] dec_sel;
  logic [7:0] port;
  logic wait_n_q, wait_n_d, err_q, err_d, armed_q, armed_d;
  logic mreq, iorq, rd, m1, mem_rd, io_rd, int_ack, cyc, start, active, timeout, is_rom;

  // synced strobes, active-high: {m1, rd, iorq, mreq}
  assign {m1, rd, iorq, mreq} = ~sync2_q;
  assign mem_rd  = mreq & rd;
  assign io_rd   = iorq & rd & !m1;
  assign int_ack = iorq & m1;
  assign cyc     = mem_rd | io_rd | int_ack;
  // armed_q means the strobes have been idle since the last accepted or rejected cycle
  assign start   = armed_q & cyc & !(mem_rd & io_rd) & !cpu_reset_req;
  assign port    = cpu_addr[7:0];
  assign is_rom  = boot_rom_en && ((cpu_addr >> 12) == {12'd0, ROM_PAGE});
  assign active  = (kind_q == K_MEM) ? mem_rd : (kind_q == K_IO) ? (iorq & rd) : iorq;
  assign timeout = active && (hold_cnt_q == 10'(HOLD_TIMEOUT - 1));
  assign dec_sel = int_ack ? 5'b00100 :
                   io_rd   ? ((port == LED_PORT) ? 5'b01000 : (port == IOBYTE_PORT) ? 5'b10000 : 5'b00100) :
                   is_rom  ? 5'b00001 : 5'b00010;
  assign dec_wait = (int_ack | io_rd) ? 6'(IO_WAIT) : is_rom ? 6'(ROM_WAIT) : 6'(RAM_WAIT);

  always_ff @(posedge pll0_250MHz) begin
    if (!n_reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      state_q    <= S_IDLE;
      kind_q     <= K_MEM;
      cs_q       <= '0;
      wait_cnt_q <= '0;
      hold_cnt_q <= '0;
      wait_n_q   <= 1'b1;
      err_q      <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      sync1_q    <= {cpu_m1_n, cpu_rd_n, cpu_iorq_n, cpu_mreq_n};
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      kind_q     <= kind_d;
      cs_q       <= cs_d;
      wait_cnt_q <= wait_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      wait_n_q   <= wait_n_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:           state_d = start ? S_DECODE : S_IDLE;
      S_DECODE, S_WAIT: state_d = (wait_cnt_q > 6'd1) ? S_WAIT : S_HOLD;
      S_HOLD:           state_d = (!active || timeout) ? S_RELEASE : S_HOLD;
      default:          state_d = S_IDLE;
    endcase
    if (cpu_reset_req) state_d = S_IDLE;
  end

  always_comb begin
    kind_d     = start ? (int_ack ? K_INT : io_rd ? K_IO : K_MEM) : kind_q;
    cs_d       = cpu_reset_req ? 6'b100000 :
                 (state_d == S_DECODE) ? {1'b0, dec_sel} :
                 (state_d == S_WAIT || state_d == S_HOLD) ? cs_q : 6'b0;
    wait_n_d   = (state_d == S_DECODE) ? (dec_wait == 6'd0) : (state_d != S_WAIT);
    wait_cnt_d = (state_q == S_IDLE) ? dec_wait : (wait_cnt_q != 6'd0) ? wait_cnt_q - 6'd1 : 6'd0;
    hold_cnt_d = (state_q != S_HOLD) ? 10'd0 : (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 10'd1;
    err_d      = err_q | (state_q == S_HOLD && timeout);
    armed_d    = !cyc || (armed_q && !(state_q == S_IDLE && !cpu_reset_req));
  end

  assign {reset_cs, iobyteIn_cs, inLED_cs, inPortcon_cs, ram_cs, rom_cs} = cs_q;
  assign cpu_wait_n  = wait_n_q;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_z80_read_cycle_ctrl.sv
// tb_z80_read_cycle_ctrl: directed and random Z80 read / int-ack cycles checked against
// a transaction-level model of target select, wait length and latencies.
module tb_z80_read_cycle_ctrl;
  localparam int MEM = 0, IO = 1, INT = 2;
  localparam int HOLD_TIMEOUT = 1023;
  logic clk = 0, n_reset = 0, mreq_n = 1, iorq_n = 1, rd_n = 1, m1_n = 1;
  logic boot_rom_en = 0, reset_req = 0;
  logic [15:0] addr = 0;
  logic rom_cs, ram_cs, inPortcon_cs, inLED_cs, iobyteIn_cs, reset_cs, wait_n, timeout_err;
  logic [5:0] sel;
  int n_checks = 0, n_fail = 0;

  assign sel = {reset_cs, iobyteIn_cs, inLED_cs, inPortcon_cs, ram_cs, rom_cs};
  always #2 clk = ~clk;

  z80_read_cycle_ctrl dut (
    .pll0_250MHz(clk), .n_reset(n_reset), .cpu_mreq_n(mreq_n), .cpu_iorq_n(iorq_n),
    .cpu_rd_n(rd_n), .cpu_m1_n(m1_n), .cpu_addr(addr), .boot_rom_en(boot_rom_en),
    .cpu_reset_req(reset_req), .rom_cs(rom_cs), .ram_cs(ram_cs), .inPortcon_cs(inPortcon_cs),
    .inLED_cs(inLED_cs), .iobyteIn_cs(iobyteIn_cs), .reset_cs(reset_cs),
    .cpu_wait_n(wait_n), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // select bits: {reset, iobyte, led, portcon, ram, rom}
  function automatic logic [5:0] model_sel(input int kd, input logic [15:0] a, input bit ren);
    int p = a % 256;
    if (kd == INT) return 6'b000100;
    if (kd == IO) return (p == 255) ? 6'b001000 : (p == 239) ? 6'b010000 : 6'b000100;
    return (ren && a >= 16'hF000) ? 6'b000001 : 6'b000010;
  endfunction

  function automatic int model_wait(input int kd, input logic [15:0] a, input bit ren);
    if (kd != MEM) return 12;
    return (ren && a >= 16'hF000) ? 6 : 4;
  endfunction

  task automatic run_read(input int kd, input logic [15:0] a, input bit ren, input int hold, input bit chk_lat);
    logic [5:0] e;
    int nw, k, nw_obs;
    e = model_sel(kd, a, ren);
    nw = model_wait(kd, a, ren);
    @(negedge clk);
    addr = a; boot_rom_en = ren;
    mreq_n = !(kd == MEM); iorq_n = (kd == MEM); rd_n = (kd == INT);
    m1_n = (kd == MEM) ? 1'($urandom_range(0, 1)) : (kd == IO);
    k = 0;
    while (sel !== e && k < 12) begin
      @(negedge clk); k++;
      chk("onehot", $countones(sel) <= 1, 1);
    end
    chk("sel_rise", sel, e);
    if (chk_lat) chk("rise_latency", k, 3);
    nw_obs = 0;
    while (wait_n === 1'b0 && nw_obs < 40) begin
      @(negedge clk); nw_obs++;
      chk("onehot", $countones(sel) <= 1, 1);
    end
    chk("wait_cycles", nw_obs, nw);
    chk("hold_sel", sel, e);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_sel", sel, e);
      chk("hold_wait_n", wait_n, 1);
    end
  endtask

  task automatic release_bus(input bit measure);
    int k;
    @(negedge clk);
    mreq_n = 1; iorq_n = 1; rd_n = 1; m1_n = 1;
    if (measure) begin
      k = 0;
      while (sel !== 6'b0 && k < 10) begin @(negedge clk); k++; end
      chk("drop_latency", k, 3);
      chk("drop_wait_n", wait_n, 1);
    end
  endtask

  task automatic no_cycle(input logic mq, input logic iq, input logic r, input logic m, input logic [15:0] a);
    @(negedge clk);
    addr = a; mreq_n = mq; iorq_n = iq; rd_n = r; m1_n = m;
    repeat (8) begin
      @(negedge clk);
      chk("no_cycle_sel", sel, 0);
      chk("no_cycle_wait_n", wait_n, 1);
    end
    @(negedge clk);
    mreq_n = 1; iorq_n = 1; rd_n = 1; m1_n = 1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k;
    logic prev_err;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_wait_n", wait_n, 1);
    chk("rst_err", timeout_err, 0);
    n_reset = 1;
    repeat (2) @(negedge clk);
    run_read(MEM, 16'hF000, 1, 2, 1); release_bus(1);
    run_read(MEM, 16'hF000, 0, 2, 1); release_bus(1);
    run_read(IO, 16'h12FF, 0, 1, 1); release_bus(1);
    run_read(IO, 16'h00EF, 0, 1, 1); release_bus(1);
    run_read(IO, 16'h0001, 0, 1, 1); release_bus(1);
    no_cycle(1, 0, 1, 1, 16'h00FF);
    no_cycle(0, 1, 1, 1, 16'h1234);
    no_cycle(0, 0, 0, 1, 16'h00FF);
    run_read(INT, 16'h0038, 0, 1, 1); release_bus(0);
    run_read(MEM, 16'h0100, 0, 1, 0); release_bus(1);
    for (int i = 0; i < 24; i++) begin
      int kd;
      logic [15:0] a;
      bit ren;
      kd = $urandom_range(0, 2);
      a = 16'($urandom);
      ren = 1'($urandom_range(0, 1));
      if (kd == MEM && $urandom_range(0, 1) == 1) a = a | 16'hF000;
      if (kd == IO) case ($urandom_range(0, 2))
        0: a[7:0] = 8'hFF;
        1: a[7:0] = 8'hEF;
        default: ;
      endcase
      run_read(kd, a, ren, $urandom_range(0, 3), 1);
      release_bus(1);
    end
    run_read(MEM, 16'hF123, 1, 0, 1);
    k = 0; prev_err = 0;
    while (sel !== 6'b0 && k < 1100) begin
      prev_err = timeout_err;
      @(negedge clk); k++;
    end
    chk("timeout_cycles", k, HOLD_TIMEOUT);
    chk("err_before", prev_err, 0);
    chk("err_set", timeout_err, 1);
    chk("timeout_wait_n", wait_n, 1);
    repeat (20) begin @(negedge clk); chk("stuck_no_sel", sel, 0); end
    @(negedge clk);
    mreq_n = 1; iorq_n = 1; rd_n = 1; m1_n = 1;
    repeat (4) @(negedge clk);
    chk("err_sticky", timeout_err, 1);
    @(negedge clk);
    addr = 16'h00FF; iorq_n = 0; rd_n = 0; m1_n = 1;
    k = 0;
    while (sel !== 6'b001000 && k < 12) begin @(negedge clk); k++; end
    chk("midrst_pre_sel", sel, 6'b001000);
    repeat (3) @(negedge clk);
    chk("midrst_in_wait", wait_n, 0);
    n_reset = 0; iorq_n = 1; rd_n = 1;
    @(negedge clk);
    chk("midrst_sel", sel, 0);
    chk("midrst_wait_n", wait_n, 1);
    chk("midrst_err", timeout_err, 0);
    n_reset = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_sel", sel, 0);
    run_read(MEM, 16'h4000, 0, 2, 1);
    reset_req = 1;
    @(negedge clk);
    chk("rreq_sel", sel, 6'b100000);
    chk("rreq_wait_n", wait_n, 1);
    mreq_n = 1; rd_n = 1; m1_n = 1;
    repeat (4) begin @(negedge clk); chk("rreq_hold", sel, 6'b100000); end
    reset_req = 0;
    @(negedge clk);
    chk("rreq_release", sel, 0);
    run_read(IO, 16'h00EF, 0, 1, 1); release_bus(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
